// File: rtl/bcd_stopwatch_pkg.sv
// rtl/bcd_stopwatch_pkg.sv - state encoding and BCD constants for the stopwatch
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 16;

  // All-9s terminal value for n_digits packed BCD digits, zero above them
  function automatic logic [4*MAX_DIGITS-1:0] bcd_all_nines(input int n_digits);
    logic [4*MAX_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n_digits) v[4*i +: 4] = BCD_MAX;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the BCD count chain
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc_en,
  output logic [3:0] q,
  output logic       at_max
);

  assign at_max = (q == BCD_MAX);

  // clear beats increment; a digit at 9 rolls over to 0 so values stay legal BCD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc_en) begin
      q <= at_max ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// rtl/bcd_stopwatch_ctrl.sv - stopwatch FSM, prescaler and BCD chain; LAP_EN adds a lap register
module bcd_stopwatch_ctrl
  import bcd_stopwatch_pkg::*;
#(
  parameter int N_DIGITS    = 3,
  parameter int TICK_DIV    = 10,
  parameter bit STOP_AT_MAX = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
`ifdef LAP_EN
  input  logic                  lap,
  output logic [4*N_DIGITS-1:0] lap_o,
`endif
  output logic [4*N_DIGITS-1:0] count_o,
  output logic                  tick,
  output logic                  running,
  output logic                  paused,
  output logic                  done
);

  localparam int            W          = 4 * N_DIGITS;
  localparam int            PW         = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  ALL_NINES  = W'(bcd_all_nines(N_DIGITS));
  // Low digit 8, all others 9: the value one increment short of terminal
  localparam logic [W-1:0]  ONE_BELOW  = ALL_NINES - W'(1);

  sw_state_t         state;
  logic [PW-1:0]     presc;
  logic [N_DIGITS:0] inc_chain;
  logic [N_DIGITS-1:0] at_max;
  logic              wrap;
  logic              hit_terminal;

  assign tick         = (state == RUN) && (presc == PRESC_LAST);
  // carry out of the top digit means every digit was 9 on this tick
  assign wrap         = inc_chain[N_DIGITS];
  assign hit_terminal = tick && (count_o == ONE_BELOW);

  assign inc_chain[0] = tick;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (clear),
      .inc_en (inc_chain[i]),
      .q      (count_o[4*i +: 4]),
      .at_max (at_max[i])
    );
    assign inc_chain[i+1] = inc_chain[i] & at_max[i];
  end

  // command FSM with prescaler; status flags are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (STOP_AT_MAX && hit_terminal) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            done <= wrap;
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
              paused  <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
            paused  <= 1'b0;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
          paused  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAP_EN
  // snapshot of the pre-increment count, taken only while timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_o <= '0;
    end else if (clear) begin
      lap_o <= '0;
    end else if (lap && ((state == RUN) || (state == PAUSE))) begin
      lap_o <= count_o;
    end
  end
`endif

endmodule
